// File: rtl/adc_idelay_tap_ctrl.sv
// Purpose: turns one ADC delay-register word into timed IODELAY CE/INC/RST pulses and tracks per-lane taps.
// Latency: a command is accepted one cycle after its bit31 toggle, and status_word is registered one cycle behind live state.
// Backpressure: none; a toggle that arrives while busy is dropped and flagged sticky in status_word[30].
module adc_idelay_tap_ctrl #(
  parameter int NUM_LANES = 8,
  parameter int TAP_WIDTH = 5,
  parameter int PULSE_GAP = 4
) (
  input  logic                 user_clk,
  input  logic                 user_rst_n,
  input  logic [31:0]          cmd_word,
  output logic [NUM_LANES-1:0] idelay_ce,
  output logic                 idelay_inc,
  output logic [NUM_LANES-1:0] idelay_rst,
  output logic                 busy,
  output logic [31:0]          status_word
);

  localparam int IDX_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int GAP_W = (PULSE_GAP > 2) ? $clog2(PULSE_GAP - 1) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_LANES - 1);
  // GAP holds PULSE_GAP-1 cycles, so it counts down from PULSE_GAP-2 to 0
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(PULSE_GAP - 2);

  typedef enum logic [2:0] {S_IDLE, S_SCAN, S_STEP, S_GAP, S_RSTP, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic                   primed_q, primed_d;
  logic                   toggle_ref_q, toggle_ref_d;
  logic [1:0]             op_q, op_d;
  logic [NUM_LANES-1:0]   mask_q, mask_d;
  logic [TAP_WIDTH-1:0]   target_q, target_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [TAP_WIDTH-1:0]   tap_q [NUM_LANES];
  logic [TAP_WIDTH-1:0]   tap_d [NUM_LANES];
  logic [7:0]             count_q, count_d;
  logic                   dropped_q, dropped_d;
  logic [31:0]            status_q, status_d;
  logic [TAP_WIDTH-1:0]   rb_tap;
  logic [2:0]             rb_sel;
  logic                   unused_cmd_bits;

  // Fields not decoded here still belong to the register word
  assign unused_cmd_bits = ^cmd_word;
  assign rb_sel          = cmd_word[26:24];
  assign status_word     = status_q;

  // State registers; reset zeroes trackers and forces a re-prime
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q      <= S_IDLE;
      primed_q     <= 1'b0;
      toggle_ref_q <= 1'b0;
      op_q         <= '0;
      mask_q       <= '0;
      target_q     <= '0;
      idx_q        <= '0;
      gap_q        <= '0;
      count_q      <= '0;
      dropped_q    <= 1'b0;
      status_q     <= '0;
      for (int l = 0; l < NUM_LANES; l++) tap_q[l] <= '0;
    end else begin
      state_q      <= state_d;
      primed_q     <= primed_d;
      toggle_ref_q <= toggle_ref_d;
      op_q         <= op_d;
      mask_q       <= mask_d;
      target_q     <= target_d;
      idx_q        <= idx_d;
      gap_q        <= gap_d;
      count_q      <= count_d;
      dropped_q    <= dropped_d;
      status_q     <= status_d;
      for (int l = 0; l < NUM_LANES; l++) tap_q[l] <= tap_d[l];
    end
  end

  // Command acceptance, sequencing FSM, pulse outputs and status assembly
  always_comb begin
    state_d      = state_q;
    primed_d     = primed_q;
    toggle_ref_d = toggle_ref_q;
    op_d         = op_q;
    mask_d       = mask_q;
    target_d     = target_q;
    idx_d        = idx_q;
    gap_d        = gap_q;
    count_d      = count_q;
    dropped_d    = dropped_q;
    tap_d        = tap_q;
    idelay_ce    = '0;
    idelay_inc   = 1'b0;
    idelay_rst   = '0;
    busy         = (state_q != S_IDLE);
    rb_tap       = '0;
    status_d     = '0;

    if (!primed_q) begin
      // Absorb whatever bit31 software left behind before reset released
      primed_d     = 1'b1;
      toggle_ref_d = cmd_word[31];
    end else if (cmd_word[31] != toggle_ref_q) begin
      toggle_ref_d = cmd_word[31];
      if (state_q == S_IDLE) begin
        op_d      = cmd_word[30:29];
        mask_d    = cmd_word[8 +: NUM_LANES];
        target_d  = cmd_word[TAP_WIDTH-1:0];
        idx_d     = '0;
        dropped_d = 1'b0;
        case (cmd_word[30:29])
          2'b00:   state_d = S_SCAN;
          2'b01:   state_d = S_RSTP;
          default: state_d = S_DONE;
        endcase
      end else begin
        dropped_d = 1'b1;
      end
    end

    case (state_q)
      S_SCAN: begin
        if (mask_q[idx_q] && (tap_q[idx_q] != target_q)) begin
          state_d = S_STEP;
        end else if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_STEP: begin
        idelay_ce[idx_q] = 1'b1;
        idelay_inc       = (target_q > tap_q[idx_q]);
        if (target_q > tap_q[idx_q]) tap_d[idx_q] = tap_q[idx_q] + TAP_WIDTH'(1);
        else                         tap_d[idx_q] = tap_q[idx_q] - TAP_WIDTH'(1);
        gap_d   = GAP_LOAD;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_q == '0) state_d = S_SCAN;
        else             gap_d   = gap_q - GAP_W'(1);
      end
      S_RSTP: begin
        idelay_rst = mask_q;
        for (int l = 0; l < NUM_LANES; l++) begin
          if (mask_q[l]) tap_d[l] = '0;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        count_d = count_q + 8'd1;
        state_d = S_IDLE;
      end
      default: ;
    endcase

    if (int'(rb_sel) < NUM_LANES) rb_tap = tap_q[rb_sel[IDX_W-1:0]];
    status_d[31]              = busy;
    status_d[30]              = dropped_q;
    status_d[23:16]           = count_q;
    status_d[TAP_WIDTH-1:0]   = rb_tap;
  end

endmodule

// File: tb/tb_adc_idelay_tap_ctrl.sv
// Directed bench for adc_idelay_tap_ctrl: a tap model predicts every pulse and busy length.
// Expected pulses are queued when a command is driven and compared against observed ones.
// Status words are checked against the model's taps, count and dropped flag.
module tb_adc_idelay_tap_ctrl;
  localparam int NL = 8;
  localparam int PG = 4;

  logic          user_clk = 1'b0;
  logic          user_rst_n = 1'b0;
  logic [31:0]   cmd_word = 32'h8000_0000;
  logic [NL-1:0] idelay_ce;
  logic          idelay_inc;
  logic [NL-1:0] idelay_rst;
  logic          busy;
  logic [31:0]   status_word;

  adc_idelay_tap_ctrl #(.NUM_LANES(NL), .TAP_WIDTH(5), .PULSE_GAP(PG)) dut (
    .user_clk(user_clk), .user_rst_n(user_rst_n), .cmd_word(cmd_word),
    .idelay_ce(idelay_ce), .idelay_inc(idelay_inc), .idelay_rst(idelay_rst),
    .busy(busy), .status_word(status_word)
  );

  always #5 user_clk = ~user_clk;

  typedef struct packed {
    logic [31:0] cyc;
    logic [7:0]  ce;
    logic        inc;
    logic [7:0]  rst;
  } ev_t;

  ev_t         obs_q[$];
  ev_t         exp_q[$];
  int          cyc = 0;
  int          busy_total = 0;
  int          checks = 0;
  int          failures = 0;
  logic [4:0]  tap_m [NL];
  logic [7:0]  exp_count = 8'd0;
  logic        exp_dropped = 1'b0;
  logic        tog = 1'b1;
  int          exp_busy = 0;
  int          busy_start = 0;

  always @(posedge user_clk) cyc <= cyc + 1;

  // Records every pulse and busy cycle at the falling edge
  always @(negedge user_clk) begin
    if (user_rst_n) begin
      if (busy) busy_total <= busy_total + 1;
      if (idelay_ce != '0 || idelay_rst != '0) begin
        ev_t e;
        e.cyc = cyc; e.ce = idelay_ce; e.inc = idelay_inc; e.rst = idelay_rst;
        obs_q.push_back(e);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive a toggled command and queue the pulses the model predicts
  task automatic start_cmd(input logic [1:0] op, input logic [7:0] mask, input logic [4:0] tgt);
    int   t;
    int   k;
    logic inc;
    ev_t  e;
    k = cyc;
    busy_start = busy_total;
    tog = ~tog;
    cmd_word = {tog, op, 2'b00, cmd_word[26:24], 8'h00, mask, 3'b000, tgt};
    exp_dropped = 1'b0;
    exp_count = exp_count + 8'd1;
    case (op)
      2'b00: begin
        t = k + 1;
        for (int i = 0; i < NL; i++) begin
          while (mask[i] && tap_m[i] != tgt) begin
            inc = (tgt > tap_m[i]);
            e.cyc = t + 1; e.ce = 8'h01 << i; e.inc = inc; e.rst = 8'h00;
            exp_q.push_back(e);
            tap_m[i] = inc ? tap_m[i] + 5'd1 : tap_m[i] - 5'd1;
            t += PG + 1;
          end
          if (i < NL - 1) t += 1;
        end
        exp_busy = t + 1 - k;
      end
      2'b01: begin
        e.cyc = k + 1; e.ce = 8'h00; e.inc = 1'b0; e.rst = mask;
        exp_q.push_back(e);
        for (int i = 0; i < NL; i++) if (mask[i]) tap_m[i] = 5'd0;
        exp_busy = 2;
      end
      default: exp_busy = 1;
    endcase
  endtask

  // Wait (bounded) for busy to fall, then compare busy length and pulses
  task automatic finish_cmd(input string tag);
    for (int i = 0; i < 3000; i++) begin
      @(negedge user_clk);
      if (!busy && i > 0) break;
    end
    chk({tag, " busy_cycles"}, 64'(busy_total - busy_start), 64'(exp_busy));
    chk({tag, " pulse_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0)
      chk({tag, " pulse"}, 64'(obs_q.pop_front()), 64'(exp_q.pop_front()));
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic check_status(input string tag, input int lane);
    cmd_word[26:24] = 3'(lane);
    repeat (2) @(negedge user_clk);
    chk(tag, 64'(status_word), 64'({1'b0, exp_dropped, 6'b0, exp_count, 11'b0, tap_m[lane]}));
  endtask

  initial begin
    bit found;
    for (int i = 0; i < NL; i++) tap_m[i] = 5'd0;

    // Reset with a stale bit31 held high
    #12;
    chk("in_reset ce", 64'(idelay_ce), 64'(0));
    chk("in_reset busy", 64'(busy), 64'(0));
    chk("in_reset status", 64'(status_word), 64'(0));
    @(negedge user_clk);
    user_rst_n = 1'b1;
    repeat (10) @(negedge user_clk);
    chk("prime no_pulses", 64'(obs_q.size()), 64'(0));
    chk("prime busy", 64'(busy), 64'(0));
    chk("prime status", 64'(status_word), 64'(0));
    tog = 1'b1;

    // Lane 0 up to 3
    start_cmd(2'b00, 8'h01, 5'd3);
    finish_cmd("set_l0_3");
    check_status("status l0=3", 0);

    // Lane 0 down to 1, then lane 7 up to 1
    start_cmd(2'b00, 8'h81, 5'd1);
    finish_cmd("set_l0_l7_1");
    check_status("status l0=1", 0);
    check_status("status l7=1", 7);

    // Toggle during a long command is dropped
    start_cmd(2'b00, 8'h02, 5'd20);
    repeat (5) @(negedge user_clk);
    tog = ~tog;
    cmd_word = {tog, 2'b00, 2'b00, cmd_word[26:24], 8'h00, 8'h04, 3'b000, 5'd5};
    exp_dropped = 1'b1;
    finish_cmd("drop");
    check_status("status dropped l1=20", 1);
    check_status("status dropped l2=0", 2);

    // Reset all taps; clears the dropped flag
    start_cmd(2'b01, 8'hFF, 5'd0);
    finish_cmd("rst_all");
    check_status("status after_rst l0", 0);
    check_status("status after_rst l1", 1);
    check_status("status after_rst l7", 7);

    // Top of tap range
    start_cmd(2'b00, 8'h10, 5'd31);
    finish_cmd("set_l4_31");
    check_status("status l4=31", 4);

    // NOPs until the completion count wraps to 0
    while (exp_count != 8'd0) begin
      start_cmd(exp_count[0] ? 2'b10 : 2'b11, 8'h00, 5'd0);
      finish_cmd("nop");
    end
    check_status("status count_wrap", 4);

    // Reset in the middle of a STEP
    tog = ~tog;
    cmd_word = {tog, 2'b00, 2'b00, 3'd0, 8'h00, 8'h01, 3'b000, 5'd10};
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge user_clk);
      if (idelay_ce != '0) begin
        found = 1'b1;
        break;
      end
    end
    chk("rst_mid ce_seen", 64'(found), 64'(1));
    #1 user_rst_n = 1'b0;
    #1;
    chk("rst_mid ce_async", 64'(idelay_ce), 64'(0));
    chk("rst_mid busy", 64'(busy), 64'(0));
    chk("rst_mid status", 64'(status_word), 64'(0));
    for (int i = 0; i < NL; i++) tap_m[i] = 5'd0;
    exp_count = 8'd0;
    exp_dropped = 1'b0;
    repeat (2) @(negedge user_clk);
    user_rst_n = 1'b1;
    repeat (3) @(negedge user_clk);
    obs_q.delete();
    check_status("status post_reset l0", 0);

    // Re-primed controller accepts a fresh command
    start_cmd(2'b00, 8'h01, 5'd2);
    finish_cmd("post_reset_set");
    check_status("status post_reset l0=2", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
